// File: rtl/hazard_pkg.sv
// Shared types for the stall/flush hazard unit.
// Watchdog states and the default register index width.
package hazard_pkg;

    localparam int REG_ADDR_W_DFLT = 5;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FAULT
    } hz_state_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter with clear and synchronous active-low reset.
// Used for the memory-wait counter and the optional perf counters.
module hz_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stall_flush_unit.sv
// Stall/flush hazard control with a data-memory watchdog FSM.
// Define PERF_COUNTERS_EN to add the StallCycles/FlushCount/LoadUseCount outputs.
module stall_flush_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DFLT,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemAckM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemErr
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]      StallCycles,
    output logic [CNT_W-1:0]      FlushCount,
    output logic [CNT_W-1:0]      LoadUseCount
`endif
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t      state;
    hz_state_t      state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           mem_wait;
    logic           lw_hazard;
    logic           at_limit;
    logic           wait_en;
    logic           wait_clr;
    logic           hold_all;
    logic           take_br;
    logic           bubble;

    assign mem_wait  = MemReqM & ~MemAckM;
    assign lw_hazard = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign at_limit  = wait_cnt == WCW'(MEM_TIMEOUT);

    // A frozen Execute stage re-presents branch and load next cycle.
    assign hold_all = (state == FAULT) | mem_wait;
    assign take_br  = ~hold_all & PCSrcE;
    assign bubble   = ~hold_all & ~PCSrcE & lw_hazard;

    assign wait_en  = mem_wait & ((state == RUN) |
                                  ((state == MEM_WAIT) & ~at_limit));
    assign wait_clr = (state == MEM_WAIT) & ~mem_wait;

    hz_sat_counter #(.W(WCW)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wait_en),
        .clr   (wait_clr),
        .count (wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            MemErr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == FAULT) begin
                MemErr <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (mem_wait) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (!mem_wait)     state_nxt = RUN;
                else if (at_limit) state_nxt = FAULT;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = hold_all | bubble;
            StallD = hold_all | bubble;
            StallE = hold_all;
            StallM = hold_all;
            FlushD = take_br;
            FlushE = take_br | bubble;
            FlushW = hold_all;
        end
    end

`ifdef PERF_COUNTERS_EN
    hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (StallF),
        .clr   (1'b0),
        .count (StallCycles)
    );

    hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (take_br),
        .clr   (1'b0),
        .count (FlushCount)
    );

    hz_sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bubble),
        .clr   (1'b0),
        .count (LoadUseCount)
    );
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_stall_flush_unit.sv
// Bench for stall_flush_unit: directed hazard scenarios plus random
// traffic checked against a cycle-level model of the hazard rules.
module tb_stall_flush_unit;

    localparam int TO    = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int NRAND = 400;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       load_e, pc_src_e, mem_req, mem_ack;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW, MemErr;
`ifdef PERF_COUNTERS_EN
    logic [CW-1:0] StallCycles, FlushCount, LoadUseCount;
`endif

    int vectors = 0;
    int miscompares = 0;

    // model state: fault flag, wait-cycle run length, counters
    bit m_fault;
    int m_waits;
    int m_stall, m_flush, m_lu;

    always #5 clk = ~clk;

    stall_flush_unit #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rs1D         (rs1),
        .Rs2D         (rs2),
        .RdE          (rd),
        .LoadE        (load_e),
        .PCSrcE       (pc_src_e),
        .MemReqM      (mem_req),
        .MemAckM      (mem_ack),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .MemErr       (MemErr)
`ifdef PERF_COUNTERS_EN
        ,
        .StallCycles  (StallCycles),
        .FlushCount   (FlushCount),
        .LoadUseCount (LoadUseCount)
`endif
    );

    function automatic logic [7:0] outs();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};
    endfunction

    function automatic bit m_lw();
        return load_e && rd != 0 && (rd == rs1 || rd == rs2);
    endfunction

    function automatic logic [7:0] model_outs();
        bit mw;
        mw = mem_req && !mem_ack;
        if (!rst_n)   return {7'b0000111, m_fault};
        if (m_fault)  return 8'b1111_0011;
        if (mw)       return 8'b1111_0010;
        if (pc_src_e) return 8'b0000_1100;
        if (m_lw())   return 8'b1100_0100;
        return 8'b0000_0000;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic drive(input bit r, input bit ld, input int d,
                         input int s1, input int s2, input bit br,
                         input bit req, input bit ack);
        rst_n    = r;
        load_e   = ld;
        rd       = 5'(d);
        rs1      = 5'(s1);
        rs2      = 5'(s2);
        pc_src_e = br;
        mem_req  = req;
        mem_ack  = ack;
    endtask

    // advance one clock and update the model from the held inputs
    task automatic tick();
        bit mw, lw, hold;
        mw   = mem_req && !mem_ack;
        lw   = m_lw();
        hold = m_fault || mw;
        @(posedge clk);
        if (!rst_n) begin
            m_fault = 0;
            m_waits = 0;
            m_stall = 0;
            m_flush = 0;
            m_lu    = 0;
        end else begin
            if (hold || (!pc_src_e && lw)) m_stall = sat(m_stall);
            if (!hold && pc_src_e)         m_flush = sat(m_flush);
            if (!hold && !pc_src_e && lw)  m_lu    = sat(m_lu);
            if (!m_fault) begin
                if (!mw)             m_waits = 0;
                else if (m_waits == TO) m_fault = 1;
                else                 m_waits++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 3, 3, 0, 1, 1, 0);
        tick();
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0000_1110) begin
            miscompares++;
            $display("FAIL reset_outs got=%b exp=%b", outs(), 8'b0000_1110);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_idle got=%b exp=%b", outs(), 8'b0);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(1, 1, 5, 5, 9, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b1100_0100) begin
            miscompares++;
            $display("FAIL lu_bubble got=%b exp=%b", outs(), 8'b1100_0100);
        end
        tick();
        drive(1, 0, 0, 5, 9, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0) begin
            miscompares++;
            $display("FAIL lu_release got=%b exp=%b", outs(), 8'b0);
        end
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0) begin
            miscompares++;
            $display("FAIL lu_x0 got=%b exp=%b", outs(), 8'b0);
        end
        tick();
`ifdef PERF_COUNTERS_EN
        vectors++;
        if (LoadUseCount !== CW'(1)) begin
            miscompares++;
            $display("FAIL lu_count got=%0d exp=1", LoadUseCount);
        end
`endif
    endtask

    task automatic test_branch_vs_load();
        drive(1, 1, 7, 2, 7, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0000_1100) begin
            miscompares++;
            $display("FAIL br_over_lu got=%b exp=%b", outs(), 8'b0000_1100);
        end
        tick();
`ifdef PERF_COUNTERS_EN
        vectors++;
        if (FlushCount !== CW'(1) || LoadUseCount !== CW'(1)) begin
            miscompares++;
            $display("FAIL br_counts got=%0d/%0d exp=1/1",
                     FlushCount, LoadUseCount);
        end
`endif
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4, 4, 0, 1, 1, 0);
            @(negedge clk);
            vectors++;
            if (outs() !== 8'b1111_0010) begin
                miscompares++;
                $display("FAIL mw_stall[%0d] got=%b exp=%b", i, outs(), 8'b1111_0010);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0) begin
            miscompares++;
            $display("FAIL mw_ack got=%b exp=%b", outs(), 8'b0);
        end
        tick();
`ifdef PERF_COUNTERS_EN
        vectors++;
        if (StallCycles !== CW'(4)) begin
            miscompares++;
            $display("FAIL mw_stall_cycles got=%0d exp=4", StallCycles);
        end
`endif
    endtask

    task automatic test_req_drop();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0) begin
            miscompares++;
            $display("FAIL drop_release got=%b exp=%b", outs(), 8'b0);
        end
        tick();
        for (int i = 0; i < TO; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0) begin
            miscompares++;
            $display("FAIL drop_no_fault got=%b exp=%b", outs(), 8'b0);
        end
        tick();
    endtask

    task automatic test_timeout();
        for (int i = 0; i <= TO; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            vectors++;
            if (outs() !== 8'b1111_0010) begin
                miscompares++;
                $display("FAIL to_wait[%0d] got=%b exp=%b", i, outs(), 8'b1111_0010);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 3, 3, 3, i == 1, 1, 1);
            @(negedge clk);
            vectors++;
            if (outs() !== 8'b1111_0011) begin
                miscompares++;
                $display("FAIL to_fault[%0d] got=%b exp=%b", i, outs(), 8'b1111_0011);
            end
            tick();
        end
    endtask

    task automatic test_fault_reset();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0000_1111) begin
            miscompares++;
            $display("FAIL fr_during got=%b exp=%b", outs(), 8'b0000_1111);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs() !== 8'b0) begin
            miscompares++;
            $display("FAIL fr_after got=%b exp=%b", outs(), 8'b0);
        end
`ifdef PERF_COUNTERS_EN
        vectors++;
        if (StallCycles !== '0 || FlushCount !== '0 || LoadUseCount !== '0) begin
            miscompares++;
            $display("FAIL fr_counters got=%0d/%0d/%0d exp=0/0/0",
                     StallCycles, FlushCount, LoadUseCount);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int n = 0; n < NRAND; n++) begin
            drive($urandom_range(0, 29) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
            @(negedge clk);
            exp = model_outs();
            vectors++;
            if (outs() !== exp) begin
                miscompares++;
                $display("FAIL rand[%0d] got=%b exp=%b", n, outs(), exp);
            end
`ifdef PERF_COUNTERS_EN
            vectors++;
            if (StallCycles !== CW'(m_stall) || FlushCount !== CW'(m_flush) ||
                LoadUseCount !== CW'(m_lu)) begin
                miscompares++;
                $display("FAIL rand_cnt[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", n,
                         StallCycles, FlushCount, LoadUseCount,
                         m_stall, m_flush, m_lu);
            end
`endif
            tick();
        end
    endtask

    initial begin
        m_fault = 0;
        m_waits = 0;
        m_stall = 0;
        m_flush = 0;
        m_lu    = 0;
        test_reset();
        test_load_use();
        test_branch_vs_load();
        test_mem_wait();
        test_req_drop();
        test_timeout();
        test_fault_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
